write_operation: RTL and testbench



---
 rtl/regfile_pkg.sv | 17 +
 rtl/write_decoder.sv | 25 ++
 rtl/write_operation.sv | 152 +++++++++++++++
 tb/tb_write_operation.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the 8-entry register file: entry count, address
// width, default data width and the write-side FSM state type.
// No ports; imported by write_decoder and write_operation.
package regfile_pkg;

  localparam int REG_COUNT      = 8;
  localparam int ADDR_W         = 3;
  localparam int DEFAULT_DATA_W = 32;

  // IDLE accepts writes; CLEAR sweeps CLR_VALUE through every entry.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } wr_state_e;

endpackage : regfile_pkg

// File: rtl/write_decoder.sv
// write_decoder
// Combinational ADDR_W-to-REG_COUNT one-hot decoder with enable. The top
// module uses one instance for the write address and one for the clear index.
// Ports:
//   en     in   1           decoder enable; output is all zero when low
//   sel    in   ADDR_W      index to decode
//   onehot out  REG_COUNT   one-hot select, bit sel set when enabled
module write_decoder
  import regfile_pkg::*;
(
  input  logic                 en,
  input  logic [ADDR_W-1:0]    sel,
  output logic [REG_COUNT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (en && (sel == ADDR_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule : write_decoder

// File: rtl/write_operation.sv
// write_operation
// Write side of the 8-entry register file. Accepts byte-strobed writes over a
// valid/ready handshake and offers a sequenced clear-all that writes
// CLR_VALUE to one entry per cycle, entry 0 first.
// Ports:
//   clk        in   1          rising-edge clock
//   reset_n    in   1          asynchronous active-low reset
//   wr_valid   in   1          write request present
//   wr_ready   out  1          write can be accepted this cycle (IDLE)
//   wAddr      in   3          target entry
//   wData      in   DATA_W     write data
//   wStrb      in   DATA_W/8   byte enables
//   clr_req    in   1          pulse that starts the clear sweep
//   busy       out  1          clear sweep in progress
//   wr_count   out  8          accepted-write counter, wraps
//   to_reg0..7 out  DATA_W     register contents, feed the read path
module write_operation
  import regfile_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wAddr,
  input  logic [DATA_W-1:0]     wData,
  input  logic [DATA_W/8-1:0]   wStrb,
  input  logic                  clr_req,
  output logic                  busy,
  output logic [7:0]            wr_count,
  output logic [DATA_W-1:0]     to_reg0,
  output logic [DATA_W-1:0]     to_reg1,
  output logic [DATA_W-1:0]     to_reg2,
  output logic [DATA_W-1:0]     to_reg3,
  output logic [DATA_W-1:0]     to_reg4,
  output logic [DATA_W-1:0]     to_reg5,
  output logic [DATA_W-1:0]     to_reg6,
  output logic [DATA_W-1:0]     to_reg7
);

  localparam int STRB_W = DATA_W / 8;

  wr_state_e             state_q;
  wr_state_e             state_d;
  logic [ADDR_W-1:0]     clr_idx_q;
  logic [DATA_W-1:0]     regs_q [REG_COUNT];
  logic [DATA_W-1:0]     byte_mask;
  logic                  wr_fire;
  logic                  clr_active;
  logic [REG_COUNT-1:0]  wr_sel;
  logic [REG_COUNT-1:0]  clr_sel;

  // A write only completes while IDLE; in CLEAR the requester holds wr_valid.
  assign wr_fire    = wr_valid && (state_q == IDLE);
  assign clr_active = (state_q == CLEAR);

  write_decoder u_wr_dec (
    .en     (wr_fire),
    .sel    (wAddr),
    .onehot (wr_sel)
  );

  write_decoder u_clr_dec (
    .en     (clr_active),
    .sel    (clr_idx_q),
    .onehot (clr_sel)
  );

  // Expand the byte strobes into a bit mask for the read-modify-write merge.
  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      byte_mask[8*b +: 8] = {8{wStrb[b]}};
    end
  end

  // State register and sweep index. The index is reloaded on every clear
  // start so an interrupted sweep never resumes part-way.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && clr_req) begin
        clr_idx_q <= '0;
      end else if (state_q == CLEAR) begin
        clr_idx_q <= clr_idx_q + ADDR_W'(1);
      end
    end
  end

  // Next state: clr_req only matters in IDLE; CLEAR ends after the last entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req) state_d = CLEAR;
      CLEAR:   if (clr_idx_q == ADDR_W'(REG_COUNT - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on the state register only.
  always_comb begin
    wr_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE:    wr_ready = 1'b1;
      CLEAR:   busy     = 1'b1;
      default: wr_ready = 1'b0;
    endcase
  end

  // Register storage. Clear and write selects never overlap because they are
  // enabled in different states, so the clear branch taking priority is moot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (clr_sel[i]) begin
          regs_q[i] <= CLR_VALUE;
        end else if (wr_sel[i]) begin
          regs_q[i] <= (regs_q[i] & ~byte_mask) | (wData & byte_mask);
        end
      end
    end
  end

  // Accepted-write counter; counts zero-strobe writes too, untouched by clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count <= '0;
    end else if (wr_fire) begin
      wr_count <= wr_count + 8'd1;
    end
  end

  assign to_reg0 = regs_q[0];
  assign to_reg1 = regs_q[1];
  assign to_reg2 = regs_q[2];
  assign to_reg3 = regs_q[3];
  assign to_reg4 = regs_q[4];
  assign to_reg5 = regs_q[5];
  assign to_reg6 = regs_q[6];
  assign to_reg7 = regs_q[7];

endmodule : write_operation

// File: tb/tb_write_operation.sv
// tb_write_operation
// Scoreboard bench for write_operation: each issued write pushes the expected
// register-file snapshot; a monitor pops and compares on every accepted write.
module tb_write_operation;

  typedef struct {
    logic [7:0][31:0] regs;
    logic [7:0]       cnt;
    logic             busy;
    logic             ready;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wAddr;
  logic [31:0] wData;
  logic [3:0]  wStrb;
  logic        clr_req;
  logic        busy;
  logic [7:0]  wr_count;
  logic [31:0] to_reg [8];

  exp_t             sb [$];
  logic [7:0][31:0] mdl_regs;
  logic [7:0]       mdl_cnt;
  int               compared;
  int               failed;

  write_operation #(
    .DATA_W    (32),
    .CLR_VALUE (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wAddr    (wAddr),
    .wData    (wData),
    .wStrb    (wStrb),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_count (wr_count),
    .to_reg0  (to_reg[0]),
    .to_reg1  (to_reg[1]),
    .to_reg2  (to_reg[2]),
    .to_reg3  (to_reg[3]),
    .to_reg4  (to_reg[4]),
    .to_reg5  (to_reg[5]),
    .to_reg6  (to_reg[6]),
    .to_reg7  (to_reg[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: bumps the counters the summary line prints.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_busy, input logic exp_ready);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s reg%0d", tag, i), to_reg[i], mdl_regs[i]);
    end
    checkOutput({tag, " wr_count"}, {24'd0, wr_count}, {24'd0, mdl_cnt});
    checkOutput({tag, " busy"}, {31'd0, busy}, {31'd0, exp_busy});
    checkOutput({tag, " wr_ready"}, {31'd0, wr_ready}, {31'd0, exp_ready});
  endtask

  // One write (optionally with a same-edge clr_req). Waits, bounded, for
  // wr_ready, then updates the model and pushes the expected snapshot.
  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic clr);
    int   n;
    exp_t e;
    @(negedge clk);
    wr_valid = 1'b1;
    wAddr    = a;
    wData    = d;
    wStrb    = s;
    clr_req  = clr;
    n = 0;
    while (!wr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) begin
      compared++;
      failed++;
      $display("[TB] FAIL ready_timeout: got wr_ready=0 expected 1 within 20 cycles");
    end else begin
      @(posedge clk);
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl_regs[a][8*b +: 8] = d[8*b +: 8];
      end
      mdl_cnt = mdl_cnt + 8'd1;
      e.regs  = mdl_regs;
      e.cnt   = mdl_cnt;
      e.busy  = clr;
      e.ready = !clr;
      sb.push_back(e);
    end
    #1;
    wr_valid = 1'b0;
    clr_req  = 1'b0;
  endtask

  // Follows the sweep after the clr edge: entry k-1 is cleared by edge k.
  task automatic check_sweep(input string tag);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      mdl_regs[k-1] = 32'h0;
      @(negedge clk);
      check_all($sformatf("%s k%0d", tag, k), k < 8, k == 8);
    end
  endtask

  // Monitor: any write the DUT accepts must match the next queued snapshot.
  initial begin
    logic fire;
    exp_t e;
    forever begin
      @(posedge clk);
      fire = wr_valid && wr_ready && reset_n;
      @(negedge clk);
      if (fire) begin
        if (sb.size() == 0) begin
          compared++;
          failed++;
          $display("[TB] FAIL unexpected_write: got accepted write expected none (count %0d)", wr_count);
        end else begin
          e = sb.pop_front();
          for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("sb reg%0d", i), to_reg[i], e.regs[i]);
          end
          checkOutput("sb wr_count", {24'd0, wr_count}, {24'd0, e.cnt});
          checkOutput("sb busy", {31'd0, busy}, {31'd0, e.busy});
          checkOutput("sb wr_ready", {31'd0, wr_ready}, {31'd0, e.ready});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] full_vals [8];
    compared = 0;
    failed   = 0;
    mdl_regs = '0;
    mdl_cnt  = 8'd0;
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wAddr    = 3'd0;
    wData    = 32'h0;
    wStrb    = 4'h0;
    clr_req  = 1'b0;
    full_vals = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                  32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};

    repeat (2) @(negedge clk);
    check_all("reset", 1'b0, 1'b1);
    reset_n = 1'b1;

    // Full-strobe writes, back to back.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'(i), full_vals[i], 4'hF, 1'b0);
    end
    @(negedge clk);
    checkOutput("full wr_count", {24'd0, wr_count}, 32'd8);

    // Byte strobe onto 0x3333_3333.
    applyStimulus(3'd2, 32'hAABB_CCDD, 4'b0101, 1'b0);
    @(negedge clk);
    checkOutput("strobe reg2", to_reg[2], 32'h33BB_33DD);

    // Clear-all with a write held pending for the whole sweep.
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req  = 1'b0;
    wr_valid = 1'b1;
    wAddr    = 3'd6;
    wData    = 32'hCAFE_F00D;
    wStrb    = 4'hF;
    check_sweep("clear");
    @(posedge clk);
    begin
      exp_t e;
      mdl_regs[6] = 32'hCAFE_F00D;
      mdl_cnt     = mdl_cnt + 8'd1;
      e.regs  = mdl_regs;
      e.cnt   = mdl_cnt;
      e.busy  = 1'b0;
      e.ready = 1'b1;
      sb.push_back(e);
    end
    #1;
    wr_valid = 1'b0;
    @(negedge clk);

    // Write and clear on the same IDLE edge.
    applyStimulus(3'd5, 32'h1234_5678, 4'hF, 1'b1);
    check_sweep("simul");

    // Reset during the 4th CLEAR cycle, with entry 7 nonzero.
    applyStimulus(3'd7, 32'hDEAD_BEEF, 4'hF, 1'b0);
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b0;
    mdl_regs = '0;
    mdl_cnt  = 8'd0;
    #1;
    check_all("rst_mid", 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_all("post_rst", 1'b0, 1'b1);

    // 256 zero-strobe writes: count wraps, contents stay zero.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(3'(i % 8), 32'hFFFF_FFFF, 4'h0, 1'b0);
    end
    @(negedge clk);
    checkOutput("wrap wr_count", {24'd0, wr_count}, 32'd0);

    repeat (2) @(negedge clk);
    checkOutput("sb drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule : tb_write_operation
